// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: read-only direct-mapped instruction cache between the
// PC and a 256-bit line memory. Hits return the word in the same cycle; misses
// hold stall_o while the line is refilled.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters
// (hit_cnt_o, miss_cnt_o).
module icache_fetch_responder #(
   parameter int unsigned NUM_LINES = 32,
   parameter int unsigned LINE_W    = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [31:0]       addr_i,
   output logic [31:0]       inst_o,
   output logic              stall_o,
   output logic              mem_enable_o,
   output logic [31:0]       mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int unsigned INDEX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W   = 32 - 5 - INDEX_W;
   localparam int unsigned WORD_W  = 32;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_FILL  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_LINES];
   logic [LINE_W-1:0]   data_q [NUM_LINES];
   logic [31:0]         mem_addr_q;

   logic [2:0]          req_word;
   logic [INDEX_W-1:0]  req_index;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  fill_index;
   logic [TAG_W-1:0]    fill_tag;
   logic                hit_c;
   logic                miss_c;
   logic                fill_c;
   logic [WORD_W-1:0]   word_c;
   logic                unused_addr_bits;

   // Split fetch and latched refill addresses into word/index/tag fields
   assign req_word   = addr_i[4:2];
   assign req_index  = addr_i[5 +: INDEX_W];
   assign req_tag    = addr_i[31 -: TAG_W];
   assign fill_index = mem_addr_q[5 +: INDEX_W];
   assign fill_tag   = mem_addr_q[31 -: TAG_W];
   assign unused_addr_bits = ^addr_i[1:0];

   assign hit_c  = valid_q[req_index] && (tag_q[req_index] == req_tag);
   assign miss_c = (state_q == S_IDLE) && req_i && !hit_c;
   assign fill_c = (state_q == S_FETCH) && mem_ack_i;
   assign word_c = data_q[req_index][{req_word, 5'b0} +: WORD_W];

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and combinational fetch outputs; reset forces outputs quiet
   always_comb begin
      state_d      = state_q;
      inst_o       = '0;
      stall_o      = 1'b0;
      mem_enable_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (hit_c) begin
                  inst_o = word_c;
               end else begin
                  stall_o = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            stall_o      = 1'b1;
            mem_enable_o = 1'b1;
            if (mem_ack_i) state_d = S_FILL;
         end
         S_FILL: begin
            stall_o = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!rst_i) begin
         inst_o       = '0;
         stall_o      = 1'b0;
         mem_enable_o = 1'b0;
      end
   end

   // Latch the line-aligned miss address; it is held until the next miss
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      mem_addr_q <= '0;
      else if (miss_c) mem_addr_q <= {addr_i[31:5], 5'b0};
   end

   assign mem_addr_o = mem_addr_q;

   // Valid bits: cleared on reset, set when a refill lands
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      valid_q <= '0;
      else if (fill_c) valid_q[fill_index] <= 1'b1;
   end

   // Tag and data arrays: written only by an acked refill, never reset
   always_ff @(posedge clk_i) begin
      if (fill_c) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= mem_data_i;
      end
   end

`ifdef ICACHE_STATS_EN
   logic hit_evt_c;
   assign hit_evt_c = (state_q == S_IDLE) && req_i && hit_c;

   // Saturating hit/miss counters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (hit_evt_c && (hit_cnt_o != 32'hFFFF_FFFF))  hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (miss_c && (miss_cnt_o != 32'hFFFF_FFFF))    miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule
